// File: rtl/branch_pkg.sv
// Shared encodings and helpers for the branch resolve stage.
// Kind/funct3 codes, BHT reset value and counter saturation.
package branch_pkg;

    localparam logic [1:0] KIND_NONE   = 2'b00;
    localparam logic [1:0] KIND_BRANCH = 2'b01;
    localparam logic [1:0] KIND_JAL    = 2'b10;
    localparam logic [1:0] KIND_JALR   = 2'b11;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [1:0] BHT_RESET = 2'b01;

    function automatic logic [1:0] sat_update(
        input logic [1:0] ctr,
        input logic       up
    );
        if (up)
            return (ctr == 2'b11) ? ctr : ctr + 2'd1;
        else
            return (ctr == 2'b00) ? ctr : ctr - 2'd1;
    endfunction

endpackage

// File: rtl/branch_compare.sv
// Operand comparator for branch conditions.
// One subtractor yields equal, unsigned-less and signed-less.
module branch_compare #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            eq,
    output logic            lt,
    output logic            ltu
);

    logic [XLEN:0] diff;

    assign diff = {1'b0, a} - {1'b0, b};
    assign eq   = (diff[XLEN-1:0] == '0);
    assign ltu  = diff[XLEN];
    // Inverting both MSBs maps signed order onto unsigned order,
    // which reverses the borrow exactly when the sign bits differ.
    assign lt   = ltu ^ a[XLEN-1] ^ b[XLEN-1];

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch/jump resolution stage: condition, target, misprediction,
// BHT training, mispredict counter and a registered valid/ready output.
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int BHT_IDX_W = 6,
    parameter bit HAS_BHT   = 1'b1
) (
    input  logic            i_Clk_1,
    input  logic            i_Rst_1,
    input  logic [XLEN-1:0] i_LookupPc_XLEN,
    output logic            o_LookupTaken_1,
    input  logic            i_Valid_1,
    output logic            o_Ready_1,
    input  logic [1:0]      i_Kind_2,
    input  logic [2:0]      i_Funct3_3,
    input  logic [XLEN-1:0] i_Pc_XLEN,
    input  logic [XLEN-1:0] i_Src1_XLEN,
    input  logic [XLEN-1:0] i_Src2_XLEN,
    input  logic [XLEN-1:0] i_Imm_XLEN,
    input  logic [XLEN-1:0] i_PredNextPc_XLEN,
    input  logic            i_Flush_1,
    output logic            o_Valid_1,
    input  logic            i_Ready_1,
    output logic            o_Taken_1,
    output logic            o_Mispredict_1,
    output logic            o_Misaligned_1,
    output logic            o_Illegal_1,
    output logic [XLEN-1:0] o_NextPc_XLEN,
    output logic [XLEN-1:0] o_LinkAddr_XLEN,
    output logic [31:0]     o_MispredCnt_32
);

    logic            eq, lt, ltu;
    logic            cond, illegal, taken;
    logic            accept, mispredict, bht_write;
    logic [XLEN-1:0] jalr_sum, target, link, next_pc;

    branch_compare #(.XLEN(XLEN)) u_cmp (
        .a   (i_Src1_XLEN),
        .b   (i_Src2_XLEN),
        .eq  (eq),
        .lt  (lt),
        .ltu (ltu)
    );

    always_comb begin
        cond    = 1'b0;
        illegal = 1'b0;
        case (i_Funct3_3)
            F3_BEQ:  cond = eq;
            F3_BNE:  cond = ~eq;
            F3_BLT:  cond = lt;
            F3_BGE:  cond = ~lt;
            F3_BLTU: cond = ltu;
            F3_BGEU: cond = ~ltu;
            default: illegal = (i_Kind_2 == KIND_BRANCH);
        endcase
    end

    always_comb begin
        taken = 1'b0;
        case (i_Kind_2)
            KIND_BRANCH: taken = cond;
            KIND_JAL:    taken = 1'b1;
            KIND_JALR:   taken = 1'b1;
            default:     taken = 1'b0;
        endcase
    end

    assign jalr_sum   = i_Src1_XLEN + i_Imm_XLEN;
    assign target     = (i_Kind_2 == KIND_JALR) ? {jalr_sum[XLEN-1:1], 1'b0}
                                                : i_Pc_XLEN + i_Imm_XLEN;
    assign link       = i_Pc_XLEN + XLEN'(4);
    assign next_pc    = taken ? target : link;
    assign mispredict = (next_pc != i_PredNextPc_XLEN);

    assign o_Ready_1  = ~o_Valid_1 | i_Ready_1;
    assign accept     = i_Valid_1 & o_Ready_1 & ~i_Flush_1;
    assign bht_write  = accept & (i_Kind_2 == KIND_BRANCH) & ~illegal;

    always_ff @(posedge i_Clk_1) begin
        if (i_Rst_1) begin
            o_Valid_1       <= 1'b0;
            o_Taken_1       <= 1'b0;
            o_Mispredict_1  <= 1'b0;
            o_Misaligned_1  <= 1'b0;
            o_Illegal_1     <= 1'b0;
            o_NextPc_XLEN   <= '0;
            o_LinkAddr_XLEN <= '0;
            o_MispredCnt_32 <= '0;
        end else if (i_Flush_1) begin
            o_Valid_1 <= 1'b0;
        end else if (accept) begin
            o_Valid_1       <= 1'b1;
            o_Taken_1       <= taken;
            o_Mispredict_1  <= mispredict;
            o_Misaligned_1  <= taken & target[1];
            o_Illegal_1     <= illegal;
            o_NextPc_XLEN   <= next_pc;
            o_LinkAddr_XLEN <= link;
            if (mispredict)
                o_MispredCnt_32 <= o_MispredCnt_32 + 32'd1;
        end else if (i_Ready_1) begin
            o_Valid_1 <= 1'b0;
        end
    end

    generate
        if (HAS_BHT) begin : g_bht
            localparam int ENTRIES = 1 << BHT_IDX_W;
            logic [1:0]           ctr [ENTRIES];
            logic [BHT_IDX_W-1:0] look_idx, upd_idx;

            assign look_idx        = i_LookupPc_XLEN[BHT_IDX_W+1:2];
            assign upd_idx         = i_Pc_XLEN[BHT_IDX_W+1:2];
            // Read is not bypassed from a same-cycle update.
            assign o_LookupTaken_1 = ctr[look_idx][1];

            always_ff @(posedge i_Clk_1) begin
                if (i_Rst_1) begin
                    for (int i = 0; i < ENTRIES; i++)
                        ctr[i] <= BHT_RESET;
                end else if (bht_write) begin
                    ctr[upd_idx] <= sat_update(ctr[upd_idx], taken);
                end
            end
        end else begin : g_no_bht
            assign o_LookupTaken_1 = 1'b0;
        end
    endgenerate

    logic unused;
    assign unused = ^{i_LookupPc_XLEN, i_Pc_XLEN, bht_write};

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: a reference model pushes
// expected results on acceptance; scenario tasks compare the head.
module tb_branch_resolve_unit;

    typedef struct packed {
        logic        taken;
        logic        mis;
        logic        misal;
        logic        ill;
        logic [31:0] next_pc;
        logic [31:0] link;
    } res_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] lpc = '0;
    logic        vin = 1'b0;
    logic [1:0]  kind = '0;
    logic [2:0]  f3 = '0;
    logic [31:0] pc = '0, s1 = '0, s2 = '0, imm = '0, pred = '0;
    logic        flush = 1'b0;
    logic        rdy = 1'b1;

    logic        o_LookupTaken_1, o_Ready_1, o_Valid_1;
    logic        o_Taken_1, o_Mispredict_1, o_Misaligned_1, o_Illegal_1;
    logic [31:0] o_NextPc_XLEN, o_LinkAddr_XLEN, o_MispredCnt_32;

    res_t        q[$];
    logic [1:0]  mb [64];
    logic        m_valid = 1'b0;
    logic [31:0] m_cnt = '0;
    int          checks = 0;
    int          fails = 0;
    res_t        got;

    assign got = {o_Taken_1, o_Mispredict_1, o_Misaligned_1, o_Illegal_1,
                  o_NextPc_XLEN, o_LinkAddr_XLEN};

    always #5 clk = ~clk;

    branch_resolve_unit #(.XLEN(32), .BHT_IDX_W(6), .HAS_BHT(1'b1)) dut (
        .i_Clk_1           (clk),
        .i_Rst_1           (rst),
        .i_LookupPc_XLEN   (lpc),
        .o_LookupTaken_1   (o_LookupTaken_1),
        .i_Valid_1         (vin),
        .o_Ready_1         (o_Ready_1),
        .i_Kind_2          (kind),
        .i_Funct3_3        (f3),
        .i_Pc_XLEN         (pc),
        .i_Src1_XLEN       (s1),
        .i_Src2_XLEN       (s2),
        .i_Imm_XLEN        (imm),
        .i_PredNextPc_XLEN (pred),
        .i_Flush_1         (flush),
        .o_Valid_1         (o_Valid_1),
        .i_Ready_1         (rdy),
        .o_Taken_1         (o_Taken_1),
        .o_Mispredict_1    (o_Mispredict_1),
        .o_Misaligned_1    (o_Misaligned_1),
        .o_Illegal_1       (o_Illegal_1),
        .o_NextPc_XLEN     (o_NextPc_XLEN),
        .o_LinkAddr_XLEN   (o_LinkAddr_XLEN),
        .o_MispredCnt_32   (o_MispredCnt_32)
    );

    function automatic res_t model(input logic [1:0] k, input logic [2:0] f,
                                   input logic [31:0] p, input logic [31:0] a,
                                   input logic [31:0] b, input logic [31:0] im,
                                   input logic [31:0] pr);
        res_t r;
        logic [31:0] tgt;
        r = '0;
        if (k == 2'b01) begin
            case (f)
                3'd0: r.taken = (a == b);
                3'd1: r.taken = (a != b);
                3'd4: r.taken = ($signed(a) < $signed(b));
                3'd5: r.taken = ($signed(a) >= $signed(b));
                3'd6: r.taken = (a < b);
                3'd7: r.taken = (a >= b);
                default: r.ill = 1'b1;
            endcase
        end else begin
            r.taken = (k != 2'b00);
        end
        tgt       = (k == 2'b11) ? ((a + im) & 32'hFFFF_FFFE) : p + im;
        r.link    = p + 32'd4;
        r.next_pc = r.taken ? tgt : r.link;
        r.mis     = (r.next_pc != pr);
        r.misal   = r.taken & tgt[1];
        return r;
    endfunction

    task automatic set_req(input logic [1:0] k, input logic [2:0] f,
                           input logic [31:0] p, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] im,
                           input logic [31:0] pr);
        kind = k; f3 = f; pc = p; s1 = a; s2 = b; imm = im; pred = pr;
    endtask

    // One clock edge; the reference model advances alongside the DUT.
    task automatic tick();
        logic acc, pop;
        res_t e;
        acc = vin && (!m_valid || rdy) && !flush;
        pop = m_valid && rdy;
        @(posedge clk);
        if (rst) begin
            m_valid = 1'b0;
            m_cnt   = '0;
            for (int i = 0; i < 64; i++) mb[i] = 2'b01;
            q.delete();
        end else if (flush) begin
            m_valid = 1'b0;
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (acc) begin
                e = model(kind, f3, pc, s1, s2, imm, pred);
                q.push_back(e);
                m_valid = 1'b1;
                if (e.mis) m_cnt = m_cnt + 32'd1;
                if (kind == 2'b01 && !e.ill) begin
                    if (e.taken && mb[pc[7:2]] != 2'b11)
                        mb[pc[7:2]] = mb[pc[7:2]] + 2'd1;
                    else if (!e.taken && mb[pc[7:2]] != 2'b00)
                        mb[pc[7:2]] = mb[pc[7:2]] - 2'd1;
                end
            end else if (pop) begin
                m_valid = 1'b0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; vin = 1'b0; flush = 1'b0; rdy = 1'b0;
        tick(); tick();
        rst = 1'b0;
        checks++;
        if (o_Valid_1 !== 1'b0 || got !== '0) begin
            fails++;
            $display("FAIL reset_out valid=%b res=%h want 0", o_Valid_1, got);
        end
        checks++;
        if (o_MispredCnt_32 !== 32'd0) begin
            fails++;
            $display("FAIL reset_cnt got=%0d want 0", o_MispredCnt_32);
        end
        checks++;
        if (o_Ready_1 !== 1'b1) begin
            fails++;
            $display("FAIL reset_ready got=%b want 1", o_Ready_1);
        end
        for (int i = 0; i < 4; i++) begin
            lpc = 32'(i * 52);
            #1;
            checks++;
            if (o_LookupTaken_1 !== 1'b0) begin
                fails++;
                $display("FAIL reset_lookup pc=%h got=%b want 0", lpc, o_LookupTaken_1);
            end
        end
        rdy = 1'b1;
    endtask

    task automatic test_compare();
        logic [2:0]  fs [6];
        logic [31:0] av [4];
        logic [31:0] bv [4];
        fs = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
        av = '{32'hFFFF_FFFF, 32'h5, 32'h8000_0000, 32'h7FFF_FFFF};
        bv = '{32'h1, 32'h5, 32'h7FFF_FFFF, 32'h8000_0000};
        rdy = 1'b1;
        vin = 1'b1;
        set_req(2'b01, 3'd4, 32'h100, 32'hFFFF_FFFF, 32'h1, 32'h20, 32'h104);
        tick();
        checks++;
        if (o_Valid_1 !== 1'b1 || o_Taken_1 !== 1'b1 || o_NextPc_XLEN !== 32'h120) begin
            fails++;
            $display("FAIL blt v=%b t=%b next=%h want 1 1 120", o_Valid_1, o_Taken_1, o_NextPc_XLEN);
        end
        set_req(2'b01, 3'd6, 32'h100, 32'hFFFF_FFFF, 32'h1, 32'h20, 32'h104);
        tick();
        checks++;
        if (o_Taken_1 !== 1'b0 || o_NextPc_XLEN !== 32'h104 || o_Mispredict_1 !== 1'b0) begin
            fails++;
            $display("FAIL bltu t=%b next=%h mis=%b want 0 104 0", o_Taken_1, o_NextPc_XLEN, o_Mispredict_1);
        end
        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < 4; j++) begin
                set_req(2'b01, fs[i], 32'h1000 + 32'(j * 4), av[j], bv[j],
                        32'hFFFF_FF00, 32'h1000 + 32'(j * 4) + 32'd4);
                tick();
                checks++;
                if (o_Valid_1 !== 1'b1 || got !== q[0]) begin
                    fails++;
                    $display("FAIL cmp f3=%0d pair=%0d got=%h want=%h", fs[i], j, got, q[0]);
                end
            end
        end
        vin = 1'b0;
        tick();
    endtask

    task automatic test_jumps();
        rdy = 1'b1;
        vin = 1'b1;
        set_req(2'b11, 3'd0, 32'h200, 32'h1003, 32'h0, 32'h4, 32'h204);
        tick();
        checks++;
        if (o_NextPc_XLEN !== 32'h1006 || o_Misaligned_1 !== 1'b1 ||
            o_LinkAddr_XLEN !== 32'h204 || got !== q[0]) begin
            fails++;
            $display("FAIL jalr got=%h want=%h", got, q[0]);
        end
        set_req(2'b10, 3'd5, 32'h300, 32'h0, 32'h0, 32'hFFFF_FFF8, 32'h2F8);
        tick();
        checks++;
        if (o_NextPc_XLEN !== 32'h2F8 || o_Mispredict_1 !== 1'b0 || got !== q[0]) begin
            fails++;
            $display("FAIL jal got=%h want=%h", got, q[0]);
        end
        set_req(2'b00, 3'd0, 32'h400, 32'h7, 32'h7, 32'h40, 32'h440);
        tick();
        checks++;
        if (o_Taken_1 !== 1'b0 || o_Mispredict_1 !== 1'b1 || got !== q[0]) begin
            fails++;
            $display("FAIL none got=%h want=%h", got, q[0]);
        end
        vin = 1'b0;
        tick();
    endtask

    task automatic test_bht_train();
        logic pre_want [3];
        pre_want = '{1'b0, 1'b1, 1'b1};
        rst = 1'b1; tick(); rst = 1'b0;
        rdy = 1'b1;
        lpc = 32'h40;
        vin = 1'b1;
        for (int k = 0; k < 3; k++) begin
            set_req(2'b01, 3'd0, 32'h40, 32'h7, 32'h7, 32'h10, 32'h44);
            #1;
            checks++;
            if (o_LookupTaken_1 !== pre_want[k] || o_LookupTaken_1 !== mb[16][1]) begin
                fails++;
                $display("FAIL bht_pre k=%0d got=%b want=%b", k, o_LookupTaken_1, pre_want[k]);
            end
            tick();
            checks++;
            if (o_Mispredict_1 !== 1'b1 || got !== q[0]) begin
                fails++;
                $display("FAIL bht_res k=%0d got=%h want=%h", k, got, q[0]);
            end
        end
        vin = 1'b0;
        tick();
        checks++;
        if (o_MispredCnt_32 !== 32'd3 || o_MispredCnt_32 !== m_cnt) begin
            fails++;
            $display("FAIL bht_cnt got=%0d want 3", o_MispredCnt_32);
        end
        checks++;
        if (o_LookupTaken_1 !== 1'b1 || mb[16] !== 2'b11) begin
            fails++;
            $display("FAIL bht_final got=%b want 1", o_LookupTaken_1);
        end
    endtask

    task automatic test_backpressure();
        res_t held;
        rdy = 1'b0;
        vin = 1'b1;
        set_req(2'b01, 3'd1, 32'h500, 32'h1, 32'h2, 32'h30, 32'h504);
        tick();
        held = q[0];
        checks++;
        if (o_Valid_1 !== 1'b1 || got !== held) begin
            fails++;
            $display("FAIL bp_first got=%h want=%h", got, held);
        end
        set_req(2'b01, 3'd7, 32'h600, 32'h9, 32'h3, 32'h8, 32'h608);
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (o_Ready_1 !== 1'b0) begin
                fails++;
                $display("FAIL bp_ready c=%0d got=%b want 0", c, o_Ready_1);
            end
            tick();
            checks++;
            if (o_Valid_1 !== 1'b1 || got !== held || q.size() != 1) begin
                fails++;
                $display("FAIL bp_hold c=%0d got=%h want=%h", c, got, held);
            end
        end
        rdy = 1'b1;
        #1;
        checks++;
        if (o_Ready_1 !== 1'b1) begin
            fails++;
            $display("FAIL bp_release got=%b want 1", o_Ready_1);
        end
        tick();
        vin = 1'b0;
        checks++;
        if (o_Valid_1 !== 1'b1 || got !== q[0] || o_NextPc_XLEN !== 32'h608) begin
            fails++;
            $display("FAIL bp_next got=%h want=%h", got, q[0]);
        end
        tick();
        checks++;
        if (o_Valid_1 !== 1'b0) begin
            fails++;
            $display("FAIL bp_drain valid=%b want 0", o_Valid_1);
        end
    endtask

    task automatic test_back_to_back();
        rdy = 1'b1;
        vin = 1'b1;
        for (int n = 0; n < 4; n++) begin
            set_req(2'(n), 3'd5, 32'h800 + 32'(n * 16), 32'(n), 32'h2,
                    32'h22, 32'h804 + 32'(n * 16));
            tick();
            checks++;
            if (o_Valid_1 !== 1'b1 || got !== q[0]) begin
                fails++;
                $display("FAIL b2b n=%0d got=%h want=%h", n, got, q[0]);
            end
        end
        vin = 1'b0;
        tick();
        checks++;
        if (o_Valid_1 !== 1'b0 || o_MispredCnt_32 !== m_cnt) begin
            fails++;
            $display("FAIL b2b_end valid=%b cnt=%0d want 0 %0d", o_Valid_1, o_MispredCnt_32, m_cnt);
        end
    endtask

    task automatic test_flush();
        rdy = 1'b0;
        vin = 1'b1;
        lpc = 32'h48;
        set_req(2'b01, 3'd0, 32'h48, 32'h1, 32'h1, 32'h8, 32'h4C);
        tick();
        set_req(2'b01, 3'd0, 32'h48, 32'h2, 32'h2, 32'h8, 32'h4C);
        flush = 1'b1;
        rdy = 1'b1;
        tick();
        flush = 1'b0;
        vin = 1'b0;
        checks++;
        if (o_Valid_1 !== 1'b0) begin
            fails++;
            $display("FAIL flush_valid got=%b want 0", o_Valid_1);
        end
        checks++;
        if (o_MispredCnt_32 !== m_cnt || o_LookupTaken_1 !== mb[18][1]) begin
            fails++;
            $display("FAIL flush_state cnt=%0d lk=%b want %0d %b",
                     o_MispredCnt_32, o_LookupTaken_1, m_cnt, mb[18][1]);
        end
    endtask

    task automatic test_illegal();
        rdy = 1'b1;
        vin = 1'b1;
        lpc = 32'h80;
        set_req(2'b01, 3'd0, 32'h80, 32'h3, 32'h3, 32'h4, 32'h84);
        tick();
        set_req(2'b01, 3'd2, 32'h80, 32'h3, 32'h3, 32'h4, 32'h84);
        tick();
        vin = 1'b0;
        checks++;
        if (o_Illegal_1 !== 1'b1 || o_Taken_1 !== 1'b0 || got !== q[0]) begin
            fails++;
            $display("FAIL illegal got=%h want=%h", got, q[0]);
        end
        tick();
        checks++;
        if (o_LookupTaken_1 !== 1'b1 || mb[32] !== 2'b10) begin
            fails++;
            $display("FAIL illegal_bht got=%b want 1", o_LookupTaken_1);
        end
    endtask

    task automatic test_reset_mid();
        rdy = 1'b0;
        vin = 1'b1;
        set_req(2'b10, 3'd0, 32'h900, 32'h0, 32'h0, 32'h40, 32'h0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vin = 1'b0;
        rdy = 1'b1;
        checks++;
        if (o_Valid_1 !== 1'b0 || o_MispredCnt_32 !== 32'd0 || got !== '0) begin
            fails++;
            $display("FAIL rst_mid valid=%b cnt=%0d res=%h want 0", o_Valid_1, o_MispredCnt_32, got);
        end
        lpc = 32'h80;
        #1;
        checks++;
        if (o_LookupTaken_1 !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid_lk got=%b want 0", o_LookupTaken_1);
        end
        lpc = 32'h40;
        vin = 1'b1;
        set_req(2'b01, 3'd0, 32'h40, 32'h1, 32'h1, 32'h8, 32'h48);
        tick();
        vin = 1'b0;
        checks++;
        if (o_LookupTaken_1 !== 1'b1 || mb[16] !== 2'b10) begin
            fails++;
            $display("FAIL rst_mid_01 got=%b want 1", o_LookupTaken_1);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mb[i] = 2'b01;
        test_reset();
        test_compare();
        test_jumps();
        test_bht_train();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_illegal();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
